rob_queue: RTL

- Parametrised reorder buffer: circular queue with allocation at the tail, N writeback ports and in-order commit at the head.
- Sits between dispatch (allocates tags), the execution units (write back results by tag) and the commit stage (retires in program order).
- Adds the following to the flat dual-port ROB storage: head/tail/count tracking, per-entry busy/ready state, a parametrised writeback port count with priority collision resolution, flush, and operand lookup.

---
 rtl/qu_common.sv | 15 +
 rtl/rob_wb_arbiter.sv | 32 +++
 rtl/rob_queue.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/qu_common.sv
// Shared ROB types and defaults for the queue core.
// Holds the default depth, the tag type and the per-entry state bundle.
package qu_common;

   localparam int ROB_DEPTH = 16;
   localparam int ROB_TAG_W = $clog2(ROB_DEPTH);

   typedef logic [ROB_TAG_W-1:0] rob_tag_t;

   typedef struct packed {
      logic busy;
      logic ready;
   } rob_state_t;

endpackage

// File: rtl/rob_wb_arbiter.sv
// Per-entry writeback selector: the lowest-index valid port targeting an
// entry wins; the entry gets a write enable and the winning port index.
module rob_wb_arbiter
   import qu_common::*;
#(
   parameter int NUM_WB = 2,
   parameter int DEPTH  = ROB_DEPTH,
   parameter int TAG_W  = $clog2(DEPTH),
   parameter int SEL_W  = (NUM_WB > 1) ? $clog2(NUM_WB) : 1
) (
   input  logic [NUM_WB-1:0]       wb_valid,
   input  logic [NUM_WB*TAG_W-1:0] wb_tag,
   output logic [DEPTH-1:0]        we,
   output logic [DEPTH*SEL_W-1:0]  sel
);

   // Scan ports high to low so the lowest matching index is the last write.
   always_comb begin
      we  = '0;
      sel = '0;
      for (int e = 0; e < DEPTH; e++) begin
         for (int i = NUM_WB - 1; i >= 0; i--) begin
            if (wb_valid[i] &&
                wb_tag[i*TAG_W +: TAG_W] == TAG_W'(e)) begin
               we[e]                  = 1'b1;
               sel[e*SEL_W +: SEL_W]  = SEL_W'(i);
            end
         end
      end
   end

endmodule

// File: rtl/rob_queue.sv
// Reorder buffer: tail allocation, tagged multi-port writeback, in-order
// commit at head, flush. Optional QU_ROB_WB_BYPASS_EN forwards writebacks.
module rob_queue
   import qu_common::*;
#(
   parameter int DEPTH  = ROB_DEPTH,
   parameter int DATA_W = 32,
   parameter int RES_W  = 32,
   parameter int NUM_WB = 2,
   parameter int TAG_W  = $clog2(DEPTH)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    flush,
   input  logic                    alloc_valid,
   output logic                    alloc_ready,
   input  logic [DATA_W-1:0]       alloc_data,
   output logic [TAG_W-1:0]        alloc_tag,
   input  logic [NUM_WB-1:0]       wb_valid,
   input  logic [NUM_WB*TAG_W-1:0] wb_tag,
   input  logic [NUM_WB*RES_W-1:0] wb_result,
   input  logic [TAG_W-1:0]        rd_tag,
   output logic                    rd_ready,
   output logic [RES_W-1:0]        rd_result,
   output logic                    commit_valid,
   input  logic                    commit_ready,
   output logic [TAG_W-1:0]        commit_tag,
   output logic [DATA_W-1:0]       commit_data,
   output logic [RES_W-1:0]        commit_result,
   output logic [TAG_W:0]          count
);

   localparam int SEL_W = (NUM_WB > 1) ? $clog2(NUM_WB) : 1;
   localparam logic [TAG_W:0] FULL_CNT = (TAG_W+1)'(DEPTH);

   rob_state_t        st_q   [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [RES_W-1:0]  res_q  [DEPTH];

   logic [TAG_W-1:0]  head_q;
   logic [TAG_W-1:0]  tail_q;
   logic [TAG_W:0]    cnt_q;

   logic [DEPTH-1:0]       wb_we;
   logic [DEPTH*SEL_W-1:0] wb_sel;
   logic [DEPTH-1:0]       wb_ok;
   logic [RES_W-1:0]       wb_val [DEPTH];

   logic alloc_fire;
   logic commit_fire;

   rob_wb_arbiter #(
      .NUM_WB (NUM_WB),
      .DEPTH  (DEPTH),
      .TAG_W  (TAG_W),
      .SEL_W  (SEL_W)
   ) u_arb (
      .wb_valid (wb_valid),
      .wb_tag   (wb_tag),
      .we       (wb_we),
      .sel      (wb_sel)
   );

   // Route each entry's winning result and drop writes to idle entries.
   always_comb begin
      logic [SEL_W-1:0] s;
      s = '0;
      for (int e = 0; e < DEPTH; e++) begin
         s         = wb_sel[e*SEL_W +: SEL_W];
         wb_val[e] = wb_result[int'(s)*RES_W +: RES_W];
         wb_ok[e]  = wb_we[e] && st_q[e].busy;
      end
   end

   assign alloc_ready = (cnt_q != FULL_CNT);
   assign alloc_tag   = tail_q;
   assign count       = cnt_q;
   assign commit_tag  = head_q;
   assign commit_data = data_q[head_q];

   assign alloc_fire  = alloc_valid && alloc_ready && !flush;
   assign commit_fire = commit_valid && commit_ready && !flush;

`ifdef QU_ROB_WB_BYPASS_EN
   // Registered view merged with a same-cycle winning writeback.
   always_comb begin
      commit_valid  = st_q[head_q].busy &&
                      (st_q[head_q].ready || wb_ok[head_q]);
      commit_result = wb_ok[head_q] ? wb_val[head_q] : res_q[head_q];
      rd_ready      = st_q[rd_tag].busy &&
                      (st_q[rd_tag].ready || wb_ok[rd_tag]);
      rd_result     = wb_ok[rd_tag] ? wb_val[rd_tag] : res_q[rd_tag];
   end
`else
   // Purely registered view of head and lookup entries.
   always_comb begin
      commit_valid  = st_q[head_q].busy && st_q[head_q].ready;
      commit_result = res_q[head_q];
      rd_ready      = st_q[rd_tag].busy && st_q[rd_tag].ready;
      rd_result     = res_q[rd_tag];
   end
`endif

   // Head, tail and occupancy; flush overrides all other traffic.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q <= '0;
         tail_q <= '0;
         cnt_q  <= '0;
      end else if (flush) begin
         head_q <= '0;
         tail_q <= '0;
         cnt_q  <= '0;
      end else begin
         if (alloc_fire)
            tail_q <= tail_q + TAG_W'(1);
         if (commit_fire)
            head_q <= head_q + TAG_W'(1);
         unique case ({alloc_fire, commit_fire})
            2'b10:   cnt_q <= cnt_q + (TAG_W+1)'(1);
            2'b01:   cnt_q <= cnt_q - (TAG_W+1)'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   // Busy/ready per entry: commit clears, alloc arms, writeback completes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int e = 0; e < DEPTH; e++)
            st_q[e] <= '0;
      end else if (flush) begin
         for (int e = 0; e < DEPTH; e++)
            st_q[e] <= '0;
      end else begin
         for (int e = 0; e < DEPTH; e++) begin
            if (commit_fire && head_q == TAG_W'(e))
               st_q[e] <= '0;
            else if (alloc_fire && tail_q == TAG_W'(e))
               st_q[e] <= '{busy: 1'b1, ready: 1'b0};
            else if (wb_ok[e])
               st_q[e].ready <= 1'b1;
         end
      end
   end

   // Payload storage is not reset; it is only observed while busy.
   always_ff @(posedge clk) begin
      if (alloc_fire)
         data_q[tail_q] <= alloc_data;
      for (int e = 0; e < DEPTH; e++) begin
         if (wb_ok[e] && !flush)
            res_q[e] <= wb_val[e];
      end
   end

endmodule
